// File: rtl/ucsbece152a_count_ctrl.sv
// Button-driven up/down counter feeding the 3-bit seven-segment decoder.
// Buttons are synchronised and edge-detected, and a run/pause FSM steps the count once per prescaled tick.
module ucsbece152a_count_ctrl #(
  parameter int WIDTH       = 3,
  parameter int TICK_DIV    = 50_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             btn_up_i,
  input  logic             btn_down_i,
  input  logic             btn_pause_i,
  output logic [WIDTH-1:0] count_o,
  output logic             dir_o,
  output logic             running_o,
  output logic             wrap_o
);

  localparam logic [1:0] ST_PAUSED   = 2'd0;
  localparam logic [1:0] ST_RUN_UP   = 2'd1;
  localparam logic [1:0] ST_RUN_DOWN = 2'd2;

  localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] COUNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_up, sync_down, sync_pause;
  logic [2:0]             prev;
  logic                   press_up, press_down, press_pause, accept;

  logic [1:0]       state, state_next;
  logic             dir, dir_next;
  logic [PW-1:0]    presc, presc_next;
  logic [WIDTH-1:0] count, count_next;
  logic             wrap, wrap_next;
  logic             running, tick, step;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_up    <= '0;
      sync_down  <= '0;
      sync_pause <= '0;
      prev       <= '0;
    end else begin
      sync_up    <= {sync_up[SYNC_STAGES-2:0], btn_up_i};
      sync_down  <= {sync_down[SYNC_STAGES-2:0], btn_down_i};
      sync_pause <= {sync_pause[SYNC_STAGES-2:0], btn_pause_i};
      prev       <= {sync_pause[SYNC_STAGES-1], sync_down[SYNC_STAGES-1], sync_up[SYNC_STAGES-1]};
    end
  end

  assign press_up    = sync_up[SYNC_STAGES-1]    & ~prev[0];
  assign press_down  = sync_down[SYNC_STAGES-1]  & ~prev[1];
  assign press_pause = sync_pause[SYNC_STAGES-1] & ~prev[2];
  // Simultaneous up+down without pause is ignored entirely, prescaler included.
  assign accept      = press_pause | (press_up ^ press_down);

  assign running = (state != ST_PAUSED);
  assign tick    = running && (presc == TICK_LAST);
  assign step    = tick && !accept;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    dir_next   = dir;
    if (press_pause) begin
      if (state == ST_PAUSED) state_next = dir ? ST_RUN_UP : ST_RUN_DOWN;
      else                    state_next = ST_PAUSED;
    end else if (press_up && !press_down) begin
      state_next = ST_RUN_UP;
      dir_next   = 1'b1;
    end else if (press_down && !press_up) begin
      state_next = ST_RUN_DOWN;
      dir_next   = 1'b0;
    end
  end

  always_comb begin
    presc_next = presc + PW'(1);
    if (accept || !running || tick) presc_next = '0;
  end

  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    if (step) begin
      if (state == ST_RUN_UP) begin
        count_next = count + WIDTH'(1);
        wrap_next  = (count == COUNT_MAX);
      end else begin
        count_next = count - WIDTH'(1);
        wrap_next  = (count == '0);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_PAUSED;
      dir   <= 1'b1;
      presc <= '0;
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= state_next;
      dir   <= dir_next;
      presc <= presc_next;
      count <= count_next;
      wrap  <= wrap_next;
    end
  end

  assign count_o   = count;
  assign dir_o     = dir;
  assign running_o = running;
  assign wrap_o    = wrap;

endmodule

// File: tb/tb_ucsbece152a_count_ctrl.sv
// Bench for ucsbece152a_count_ctrl: a cycle-level behavioural model checked every cycle,
// plus hand-computed literal expectations for the directed scenarios.
module tb_ucsbece152a_count_ctrl;

  localparam int WIDTH = 3;
  localparam int TICK  = 4;
  localparam int S     = 2;
  localparam int MODV  = 2 ** WIDTH;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             btn_up, btn_down, btn_pause;
  logic [WIDTH-1:0] count;
  logic             dir, running, wrap;

  int n_cmp = 0;
  int n_bad = 0;
  int wrap_cnt = 0;
  bit cmp_en = 1'b0;

  ucsbece152a_count_ctrl #(.WIDTH(WIDTH), .TICK_DIV(TICK), .SYNC_STAGES(S)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .btn_up_i    (btn_up),
    .btn_down_i  (btn_down),
    .btn_pause_i (btn_pause),
    .count_o     (count),
    .dir_o       (dir),
    .running_o   (running),
    .wrap_o      (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: button sample history (index 0 = newest), run flag, direction,
  // cycles since the run (re)started, and the displayed count.
  logic [S:0] h_up, h_dn, h_pa;
  bit m_run, m_dir, m_wrap;
  int m_count, m_age;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_up = '0; h_dn = '0; h_pa = '0;
      m_run = 0; m_dir = 1; m_wrap = 0; m_count = 0; m_age = 0;
    end else begin
      bit pu, pd, pp;
      pu = h_up[S-1] && !h_up[S];
      pd = h_dn[S-1] && !h_dn[S];
      pp = h_pa[S-1] && !h_pa[S];
      h_up = {h_up[S-1:0], btn_up};
      h_dn = {h_dn[S-1:0], btn_down};
      h_pa = {h_pa[S-1:0], btn_pause};
      m_wrap = 0;
      if (pp || (pu != pd)) begin
        if (pp)      m_run = !m_run;
        else if (pu) begin m_run = 1; m_dir = 1; end
        else         begin m_run = 1; m_dir = 0; end
        m_age = 0;
      end else if (m_run) begin
        m_age++;
        if (m_age == TICK) begin
          m_age = 0;
          if (m_dir) begin m_wrap = (m_count == MODV - 1); m_count = (m_count + 1) % MODV; end
          else       begin m_wrap = (m_count == 0);        m_count = (m_count + MODV - 1) % MODV; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model count", 32'(count), 32'(m_count));
      check("model dir", 32'(dir), 32'(m_dir));
      check("model running", 32'(running), 32'(m_run));
      check("model wrap", 32'(wrap), 32'(m_wrap));
      if (wrap === 1'b1) wrap_cnt++;
    end
  end

  function automatic int sel(input int which);
    case (which)
      0:       return int'(running);
      1:       return int'(dir);
      default: return int'(count);
    endcase
  endfunction

  task automatic wait_until(input int which, input int val, input string name);
    int n = 0;
    while (sel(which) != val && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out, value %0d, wanted %0d", name, sel(which), val);
    end
  endtask

  task automatic press(input logic u, input logic d, input logic p, input int hold);
    #1;
    btn_up = u; btn_down = d; btn_pause = p;
    repeat (hold) @(negedge clk);
    #1;
    btn_up = 0; btn_down = 0; btn_pause = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; btn_up = 0; btn_down = 0; btn_pause = 0;
    cmp_en = 1;
    #23 rst_n = 1;

    // 1) idle after reset
    repeat (40) @(negedge clk);
    check("idle count", 32'(count), 0);
    check("idle running", 32'(running), 0);
    check("idle dir", 32'(dir), 1);
    check("idle wrap count", 32'(wrap_cnt), 0);

    // 2) hold up: steps every TICK cycles, wrap at 7->0
    #1 btn_up = 1;
    wait_until(0, 1, "up start");
    check("up start count", 32'(count), 0);
    for (int i = 1; i <= 8; i++) begin
      repeat (TICK) @(negedge clk);
      check("up step count", 32'(count), 32'(i % MODV));
      check("up step wrap", 32'(wrap), 32'(i == 8));
      if (i == 2) btn_up = 0;
    end
    repeat (2 * TICK) @(negedge clk);
    check("up at two", 32'(count), 2);

    // 3) down from 2: 1,0,7 with wrap on 7
    press(0, 1, 0, 3);
    wait_until(1, 0, "down dir");
    for (int j = 0; j < 3; j++) begin
      repeat (TICK) @(negedge clk);
      check("down step count", 32'(count), 32'((MODV + 1 - j) % MODV));
      check("down step wrap", 32'(wrap), 32'(j == 2));
    end

    // 4) run up to 5, pause, hold, resume
    press(1, 0, 0, 3);
    wait_until(2, 5, "reach five");
    press(0, 0, 1, 2);
    wait_until(0, 0, "pause");
    repeat (20) @(negedge clk);
    check("paused count", 32'(count), 5);
    check("paused running", 32'(running), 0);
    check("paused dir", 32'(dir), 1);
    press(0, 0, 1, 2);
    wait_until(0, 1, "resume");
    check("resume count", 32'(count), 5);
    repeat (TICK) @(negedge clk);
    check("resume first step", 32'(count), 6);

    // 5) up+down together while paused, then pause+up while running
    press(0, 0, 1, 2);
    wait_until(0, 0, "pause again");
    press(1, 1, 0, 3);
    repeat (5) @(negedge clk);
    check("up+down running", 32'(running), 0);
    check("up+down count", 32'(count), 6);
    check("up+down dir", 32'(dir), 1);
    press(1, 0, 0, 3);
    wait_until(0, 1, "rerun");
    repeat (2) @(negedge clk);
    press(1, 0, 1, 3);
    wait_until(0, 0, "pause+up");
    repeat (5) @(negedge clk);
    check("pause+up running", 32'(running), 0);
    check("pause+up dir", 32'(dir), 1);

    // 6) asynchronous reset mid-run with a press in flight
    press(0, 0, 1, 2);
    wait_until(0, 1, "run before reset");
    @(negedge clk);
    #1 btn_down = 1;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("async rst count", 32'(count), 0);
    check("async rst running", 32'(running), 0);
    check("async rst dir", 32'(dir), 1);
    check("async rst wrap", 32'(wrap), 0);
    btn_down = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    repeat (10) @(negedge clk);
    check("post rst count", 32'(count), 0);
    check("post rst running", 32'(running), 0);
    check("post rst dir", 32'(dir), 1);

    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
